// File: rtl/firebird7_in_gate1_tessent_tdr_pkg.sv
// Shared constants for the IJTAG data-mux control TDR: widths, bit positions, reset values.
package firebird7_in_gate1_tessent_tdr_pkg;

  localparam int unsigned DATA_W_DEF = 3;
  localparam int unsigned SR_W_DEF   = DATA_W_DEF + 2;
  localparam int unsigned CLR_BIT_DEF = DATA_W_DEF;
  localparam int unsigned SEL_BIT_DEF = DATA_W_DEF + 1;

  localparam logic UPD_SELECT_RST = 1'b0;
  localparam logic FLAG_RST       = 1'b0;

  // Bit positions derived from an arbitrary data width.
  function automatic int unsigned clr_bit(input int unsigned data_w);
    return data_w;
  endfunction

  function automatic int unsigned sel_bit(input int unsigned data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_tdr_mux_ctl_w3.sv
// IJTAG TDR that drives a data-mux select/data leg and observes the mux output,
// keeping a sticky flag when the observed data disagrees with what was applied.
module firebird7_in_gate1_tessent_tdr_mux_ctl_w3
  import firebird7_in_gate1_tessent_tdr_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              ijtag_tck,
  input  logic              ijtag_reset,
  input  logic              ijtag_sel,
  input  logic              ijtag_ce,
  input  logic              ijtag_se,
  input  logic              ijtag_ue,
  input  logic              ijtag_si,
  output logic              ijtag_so,
  input  logic [DATA_W-1:0] observed_data,
  output logic              ijtag_select,
  output logic [DATA_W-1:0] ijtag_data_in
);

  localparam int unsigned SR_W    = DATA_W + 2;
  localparam int unsigned CLR_BIT = clr_bit(DATA_W);
  localparam int unsigned SEL_BIT = sel_bit(DATA_W);

  logic [SR_W-1:0]   sr, sr_nxt;
  logic              upd_select, upd_select_nxt;
  logic [DATA_W-1:0] upd_data, upd_data_nxt;
  logic              mismatch_flag, mismatch_flag_nxt;

  // Next-state: capture beats shift; update always samples the pre-edge sr.
  always_comb begin
    sr_nxt            = sr;
    upd_select_nxt    = upd_select;
    upd_data_nxt      = upd_data;
    mismatch_flag_nxt = mismatch_flag;

    if (ijtag_sel) begin
      if (ijtag_ce) begin
        sr_nxt = {upd_select, mismatch_flag, observed_data};
      end else if (ijtag_se) begin
        sr_nxt = {ijtag_si, sr[SR_W-1:1]};
      end
      if (ijtag_ue) begin
        upd_select_nxt = sr[SEL_BIT];
        upd_data_nxt   = sr[DATA_W-1:0];
      end
    end

    if (upd_select && (observed_data != upd_data)) begin
      mismatch_flag_nxt = 1'b1;
    end
    // Clear wins; a persisting mismatch re-sets the flag on the following edge.
    if (ijtag_sel && ijtag_ue && sr[CLR_BIT]) begin
      mismatch_flag_nxt = 1'b0;
    end
  end

  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      sr            <= '0;
      upd_select    <= UPD_SELECT_RST;
      upd_data      <= '0;
      mismatch_flag <= FLAG_RST;
    end else begin
      sr            <= sr_nxt;
      upd_select    <= upd_select_nxt;
      upd_data      <= upd_data_nxt;
      mismatch_flag <= mismatch_flag_nxt;
    end
  end

  assign ijtag_so      = sr[0];
  assign ijtag_select  = upd_select;
  assign ijtag_data_in = upd_data;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_mux_ctl_w3.sv
// Randomized and directed bench for the data-mux control TDR against a behavioural model.
module tb_firebird7_in_gate1_tessent_tdr_mux_ctl_w3;

  localparam int DW   = 3;
  localparam int SRW  = DW + 2;
  localparam int DMAX = 2 ** DW;

  logic          ijtag_tck = 1'b0;
  logic          ijtag_reset, ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si;
  logic          ijtag_so, ijtag_select;
  logic [DW-1:0] observed_data, ijtag_data_in;

  int checks = 0;
  int errors = 0;

  // Reference state as plain integers.
  int m_sr, m_sel, m_data, m_flag;

  firebird7_in_gate1_tessent_tdr_mux_ctl_w3 #(.DATA_W(DW)) dut (
    .ijtag_tck     (ijtag_tck),
    .ijtag_reset   (ijtag_reset),
    .ijtag_sel     (ijtag_sel),
    .ijtag_ce      (ijtag_ce),
    .ijtag_se      (ijtag_se),
    .ijtag_ue      (ijtag_ue),
    .ijtag_si      (ijtag_si),
    .ijtag_so      (ijtag_so),
    .observed_data (observed_data),
    .ijtag_select  (ijtag_select),
    .ijtag_data_in (ijtag_data_in)
  );

  always #5 ijtag_tck = ~ijtag_tck;

  initial begin
    #2000000;
    $display("FAIL timeout got running required finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d required %0d", tag, got, exp);
    end
  endtask

  // One clock: apply inputs, advance the model, compare everything after the edge.
  task automatic step(input logic rst, input logic sel, input logic ce,
                      input logic se, input logic ue, input logic si);
    int n_sr, n_sel, n_data, n_flag, obs;
    ijtag_reset = rst; ijtag_sel = sel; ijtag_ce = ce;
    ijtag_se = se; ijtag_ue = ue; ijtag_si = si;
    obs = int'(observed_data);
    if (rst) begin
      n_sr = 0; n_sel = 0; n_data = 0; n_flag = 0;
    end else begin
      n_sr = m_sr; n_sel = m_sel; n_data = m_data; n_flag = m_flag;
      if (sel && ce)      n_sr = m_sel * 2 * DMAX + m_flag * DMAX + obs;
      else if (sel && se) n_sr = (m_sr / 2) + int'(si) * 2 * DMAX;
      if (sel && ue) begin
        n_sel  = (m_sr / (2 * DMAX)) % 2;
        n_data = m_sr % DMAX;
      end
      if (m_sel == 1 && obs != m_data) n_flag = 1;
      if (sel && ue && ((m_sr / DMAX) % 2) == 1) n_flag = 0;
    end
    @(posedge ijtag_tck);
    #1;
    m_sr = n_sr; m_sel = n_sel; m_data = n_data; m_flag = n_flag;
    check("so",     int'(ijtag_so),          m_sr % 2);
    check("select", int'(ijtag_select),      m_sel);
    check("data",   int'(ijtag_data_in),     m_data);
    check("sr",     int'(dut.sr),            m_sr);
    check("flag",   int'(dut.mismatch_flag), m_flag);
  endtask

  task automatic shift_bit(input logic b);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, b);
  endtask

  initial begin
    logic [4:0] pat;
    ijtag_reset = 1'b1; ijtag_sel = 1'b0; ijtag_ce = 1'b0;
    ijtag_se = 1'b0; ijtag_ue = 1'b0; ijtag_si = 1'b0;
    observed_data = 3'b000;
    m_sr = 0; m_sel = 0; m_data = 0; m_flag = 0;

    step(1'b1, 1'b0, 1'b0, 0, 0, 0);
    step(1'b1, 1'b1, 1'b1, 1, 1, 1);
    check("rst_select", int'(ijtag_select), 0);
    check("rst_data",   int'(ijtag_data_in), 0);
    check("rst_so",     int'(ijtag_so), 0);

    // Shift 1,0,1,0,1 and update.
    observed_data = 3'b101;
    pat = 5'b10101;
    for (int i = 0; i < 5; i++) shift_bit(pat[i]);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("upd_select", int'(ijtag_select), 1);
    check("upd_data",   int'(ijtag_data_in), 5);
    check("upd_flag",   int'(dut.mismatch_flag), 0);

    // Mismatch, capture, shift out.
    observed_data = 3'b100;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("cap_so0", int'(ijtag_so), 0);
    pat = 5'b11100;
    for (int i = 1; i < 5; i++) begin
      shift_bit(1'b0);
      check("cap_so_seq", int'(ijtag_so), int'(pat[i]));
    end

    // Clear with sr = 1_1_101 while mismatch persists.
    pat = 5'b11101;
    for (int i = 0; i < 5; i++) shift_bit(pat[i]);
    check("flag_before_clr", int'(dut.mismatch_flag), 1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("flag_cleared", int'(dut.mismatch_flag), 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("flag_reset_again", int'(dut.mismatch_flag), 1);

    // Enables ignored while deselected.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("desel_sr", int'(dut.sr), 5'b11101);

    // ce+se+ue together: capture wins, update from pre-edge sr.
    observed_data = 3'b010;
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("cse_sr",   int'(dut.sr), 5'b11010);
    check("cse_data", int'(ijtag_data_in), 5);

    // Reset mid-shift.
    shift_bit(1'b1);
    shift_bit(1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    check("mid_rst_select", int'(ijtag_select), 0);
    check("mid_rst_data",   int'(ijtag_data_in), 0);
    check("mid_rst_so",     int'(ijtag_so), 0);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) observed_data = DW'($urandom);
      else observed_data = DW'(m_data);
      step(logic'($urandom_range(0, 49) == 0),
           logic'($urandom_range(0, 7) != 0),
           logic'($urandom_range(0, 5) == 0),
           logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 6) == 0),
           logic'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/firebird7_in_gate1_tessent_tdr_mux_ctl_w3.md
FIREBIRD7_IN_GATE1_TESSENT_TDR_MUX_CTL_W3 -- requirements
Module: firebird7_in_gate1_tessent_tdr_mux_ctl_w3

Interface
REQ-001 SHALL use parameter DATA_W, default 3, meaning the width of the controlled and observed data path.
REQ-002 SHALL use one clock and a synchronous, active-high reset: ijtag_tck input 1, the sole clock; all state updates on its rising edge.
REQ-003 SHALL have ijtag_reset input 1: synchronous, active-high reset.
REQ-004 SHALL have ijtag_sel input 1: TDR selected on the IJTAG network.
REQ-005 SHALL have ijtag_ce input 1: capture enable.
REQ-006 SHALL have ijtag_se input 1: shift enable.
REQ-007 SHALL have ijtag_ue input 1: update enable.
REQ-008 SHALL have ijtag_si input 1: scan-in.
REQ-009 SHALL have ijtag_so output 1: scan-out, equal to sr[0] (combinational).
REQ-010 SHALL have observed_data input DATA_W: the data-mux output, fed back for observation.
REQ-011 SHALL have ijtag_select output DATA_W-independent 1: drives the data-mux select.
REQ-012 SHALL have ijtag_data_in output DATA_W: drives the data-mux IJTAG data leg.

Function
REQ-013 SHALL hold a shift register sr of SR_W = DATA_W+2 bits: sr[DATA_W-1:0] data, sr[DATA_W] CLR/flag bit, sr[DATA_W+1] SEL bit.
REQ-014 SHALL capture when ijtag_sel & ijtag_ce: sr[DATA_W-1:0] <= observed_data, sr[DATA_W] <= mismatch flag, sr[DATA_W+1] <= upd_select.
REQ-015 SHALL shift when ijtag_sel & ijtag_se & !ijtag_ce: sr <= {ijtag_si, sr[SR_W-1:1]}, LSB out first.
REQ-016 SHALL give capture priority over shift when both are asserted; sr SHALL hold when neither applies.
REQ-017 SHALL update when ijtag_sel & ijtag_ue, sampling sr as it is before that edge: upd_select <= sr[DATA_W+1], upd_data <= sr[DATA_W-1:0].
REQ-018 SHALL make the update independent of a same-cycle capture or shift.
REQ-019 SHALL ignore ce/se/ue entirely while ijtag_sel = 0; all registers hold.
REQ-020 SHALL drive ijtag_select = upd_select and ijtag_data_in = upd_data directly from registers, one cycle after the update edge, with no glitch path from sr.
REQ-021 SHALL maintain a sticky mismatch flag, set on any edge where upd_select = 1 and observed_data != upd_data.
REQ-022 SHALL clear the mismatch flag on an update edge with sr[DATA_W] = 1; clear wins over a same-edge set, and the flag re-sets on the next edge if the mismatch persists.
REQ-023 SHALL treat the mismatch comparison as registered; observed_data is sampled and not combinationally forwarded.

Reset
REQ-024 SHALL, on ijtag_reset = 1 at a rising edge, set sr = 0, upd_select = 0, upd_data = 0 and flag = 0, overriding all enables.
REQ-025 SHALL, after reset, give ijtag_select = 0 (functional path), ijtag_data_in = 0 and ijtag_so = 0.
REQ-026 SHALL discard the partial shift when reset occurs mid-shift; no update occurs on that edge.

Structure
REQ-027 SHALL place DATA_W default, SR_W, bit positions SEL_BIT/CLR_BIT and the reset values in package firebird7_in_gate1_tessent_tdr_pkg.
REQ-028 SHALL be a single module with no sub-module; it instantiates alongside the data mux, never inside it.

Verification
REQ-029 SHALL cover: reset, then shift bits 1,0,1,0,1 (LSB first), then update -> ijtag_select = 1, ijtag_data_in = 3'b101, flag = 0.
REQ-030 SHALL cover: with select = 1 and data 3'b101, drive observed_data = 3'b100, then capture and shift out 5 bits -> ijtag_so sequence 0,0,1,1,1.
REQ-031 SHALL cover: flag set, then update with sr = 5'b1_1_101 while the mismatch persists -> flag 0 for one cycle, then 1 again.
REQ-032 SHALL cover: ce, se and ue pulsed with ijtag_sel = 0 -> sr, outputs and flag unchanged.
REQ-033 SHALL cover: ce and se in the same cycle -> captured value loaded, no shift; ue in the same cycle updates from the pre-edge sr.
REQ-034 SHALL cover: ijtag_reset asserted after 2 of 5 shift cycles -> ijtag_select = 0, ijtag_data_in = 0, ijtag_so = 0 on the next cycle.
